// File: rtl/ram_arbiter.sv
// ram_arbiter: serialises two requesters' read/write commands onto one single-port synchronous RAM.
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins contention); default is round-robin.
module ram_arbiter #(
    parameter int DATA_WIDTH    = 5,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     req0_valid,
    input  logic                     req0_we,
    input  logic [ADDRESS_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0]    req0_wdata,
    output logic                     req0_ready,
    output logic                     req0_rvalid,
    output logic [DATA_WIDTH-1:0]    req0_rdata,

    input  logic                     req1_valid,
    input  logic                     req1_we,
    input  logic [ADDRESS_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0]    req1_wdata,
    output logic                     req1_ready,
    output logic                     req1_rvalid,
    output logic [DATA_WIDTH-1:0]    req1_rdata,

    output logic                     ram_wr_en,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0]    ram_data_in,
    input  logic [DATA_WIDTH-1:0]    ram_data_out,

    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RWAIT = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;

    logic                     r_winner;
    logic                     r_op_we;
    logic                     r_ram_wr_en;
    logic [ADDRESS_WIDTH-1:0] r_ram_address;
    logic [DATA_WIDTH-1:0]    r_ram_data_in;
    logic                     r_rvalid0;
    logic                     r_rvalid1;
    logic [DATA_WIDTH-1:0]    r_rdata0;
    logic [DATA_WIDTH-1:0]    r_rdata1;
`ifndef RAM_ARB_FIXED_PRIO_EN
    logic                     r_last_grant;
`endif

    logic                     w_grant0;
    logic                     w_grant1;
    logic                     w_grant_any;
    logic                     w_sel_we;
    logic [ADDRESS_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0]    w_sel_wdata;

    // Grant is combinational from valid so the transfer happens in the same IDLE cycle.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (r_state == IDLE) begin
            if (req0_valid && req1_valid) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                w_grant0 = 1'b1;
`else
                w_grant0 = r_last_grant;
                w_grant1 = ~r_last_grant;
`endif
            end else begin
                w_grant0 = req0_valid;
                w_grant1 = req1_valid;
            end
        end
    end

    assign w_grant_any = w_grant0 | w_grant1;
    assign w_sel_we    = w_grant1 ? req1_we    : req0_we;
    assign w_sel_addr  = w_grant1 ? req1_addr  : req0_addr;
    assign w_sel_wdata = w_grant1 ? req1_wdata : req0_wdata;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_grant_any) w_state_next = ISSUE;
            ISSUE:   w_state_next = r_op_we ? IDLE : RWAIT;
            RWAIT:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_winner      <= 1'b0;
            r_op_we       <= 1'b0;
            r_ram_wr_en   <= 1'b1;
            r_ram_address <= '0;
            r_ram_data_in <= '0;
            r_rvalid0     <= 1'b0;
            r_rvalid1     <= 1'b0;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
            r_last_grant  <= 1'b1;
`endif
        end else begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_any) begin
                        r_ram_address <= w_sel_addr;
                        r_ram_data_in <= w_sel_wdata;
                        r_ram_wr_en   <= ~w_sel_we;
                        r_winner      <= w_grant1;
                        r_op_we       <= w_sel_we;
`ifndef RAM_ARB_FIXED_PRIO_EN
                        r_last_grant  <= w_grant1;
`endif
                    end
                end
                ISSUE: r_ram_wr_en <= 1'b1;
                RWAIT: begin
                    // RAM output is registered, so the word is valid only in this state.
                    if (r_winner) begin
                        r_rdata1  <= ram_data_out;
                        r_rvalid1 <= 1'b1;
                    end else begin
                        r_rdata0  <= ram_data_out;
                        r_rvalid0 <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;
    assign req0_rvalid = r_rvalid0;
    assign req1_rvalid = r_rvalid1;
    assign req0_rdata  = r_rdata0;
    assign req1_rdata  = r_rdata1;
    assign ram_wr_en   = r_ram_wr_en;
    assign ram_address = r_ram_address;
    assign ram_data_in = r_ram_data_in;
    assign busy        = (r_state != IDLE);

endmodule
